// File: rtl/cattrap_game_fsm_pkg.sv
// rtl/cattrap_game_fsm_pkg.sv - CatTrap state codes, grid constants and cell helpers
package cattrap_pkg;

  localparam int GRID_N = 8;

  localparam logic [2:0] ST_START    = 3'b001;
  localparam logic [2:0] ST_PLAY     = 3'b010;
  localparam logic [2:0] ST_CAT_SCAN = 3'b011;
  localparam logic [2:0] ST_GAMEOVER = 3'b100;
  localparam logic [2:0] ST_GAMEWIN  = 3'b101;
  localparam logic [2:0] ST_PREBLOCK = 3'b110;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] score;
  } cand_t;

  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  // Distance to the nearest board edge; 0 means the cell is on the rim.
  function automatic logic [2:0] edge_dist(input logic [2:0] row, input logic [2:0] col);
    logic [2:0] dr;
    logic [2:0] dc;
    dr = (row < 3'd4) ? row : 3'd7 - row;
    dc = (col < 3'd4) ? col : 3'd7 - col;
    return (dr < dc) ? dr : dc;
  endfunction

endpackage

// File: rtl/cattrap_game_fsm_if.sv
// rtl/cattrap_game_fsm_if.sv - button pulses in, board/cursor/game state out
interface cattrap_game_fsm_if;
  logic        BtnC;
  logic        BtnU;
  logic        BtnD;
  logic        BtnL;
  logic        BtnR;
  logic [63:0] blocked;
  logic [2:0]  cat_row;
  logic [2:0]  cat_col;
  logic [7:0]  Row;
  logic [7:0]  Col;
  logic [2:0]  state;
  logic [6:0]  move_count;

  modport master (
    output BtnC, BtnU, BtnD, BtnL, BtnR,
    input  blocked, cat_row, cat_col, Row, Col, state, move_count
  );

  modport slave (
    input  BtnC, BtnU, BtnD, BtnL, BtnR,
    output blocked, cat_row, cat_col, Row, Col, state, move_count
  );
endinterface

// File: rtl/cattrap_game_fsm_lfsr16.sv
// rtl/cattrap_game_fsm_lfsr16.sv - free-running 16-bit Galois LFSR, taps 16,14,13,11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/cattrap_game_fsm.sv
// rtl/cattrap_game_fsm.sv - CatTrap board, cursor and cat-move FSM
// Define CATTRAP_PREBLOCK_EN to pre-block random cells from an LFSR at game start.
module cattrap_game_fsm
  import cattrap_pkg::*;
#(
  parameter int CAT_START_ROW = 3,
  parameter int CAT_START_COL = 3
`ifdef CATTRAP_PREBLOCK_EN
  ,
  parameter int          PREBLOCK_COUNT = 6,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  cattrap_game_fsm_if.slave bus
);

  localparam logic [2:0] LAST      = 3'(GRID_N - 1);
  localparam logic [2:0] START_ROW = 3'(CAT_START_ROW);
  localparam logic [2:0] START_COL = 3'(CAT_START_COL);

  logic [2:0]  state_q;
  logic [63:0] blocked_q;
  logic [2:0]  cat_row_q;
  logic [2:0]  cat_col_q;
  logic [2:0]  cur_row_q;
  logic [2:0]  cur_col_q;
  logic [6:0]  move_count_q;
  logic [2:0]  scan_idx_q;
  cand_t       best_q;

  logic [2:0] nb_row;
  logic [2:0] nb_col;
  logic [2:0] nb_score;
  logic       nb_in;
  logic       nb_take;

  // scan_idx 0..3 walks up, down, left, right; strict < keeps the earliest of equal scores
  always_comb begin
    nb_row = cat_row_q;
    nb_col = cat_col_q;
    nb_in  = 1'b0;
    case (scan_idx_q[1:0])
      2'd0: begin
        nb_in  = (cat_row_q != 3'd0);
        nb_row = cat_row_q - 3'd1;
      end
      2'd1: begin
        nb_in  = (cat_row_q != LAST);
        nb_row = cat_row_q + 3'd1;
      end
      2'd2: begin
        nb_in  = (cat_col_q != 3'd0);
        nb_col = cat_col_q - 3'd1;
      end
      default: begin
        nb_in  = (cat_col_q != LAST);
        nb_col = cat_col_q + 3'd1;
      end
    endcase
    nb_score = edge_dist(nb_row, nb_col);
    nb_take  = nb_in && !blocked_q[cell_index(nb_row, nb_col)]
               && (!best_q.valid || (nb_score < best_q.score));
  end

  logic [2:0] cur_row_d;
  logic [2:0] cur_col_d;

  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    if (bus.BtnU) begin
      if (cur_row_q != 3'd0) cur_row_d = cur_row_q - 3'd1;
    end else if (bus.BtnD) begin
      if (cur_row_q != LAST) cur_row_d = cur_row_q + 3'd1;
    end else if (bus.BtnL) begin
      if (cur_col_q != 3'd0) cur_col_d = cur_col_q - 3'd1;
    end else if (bus.BtnR) begin
      if (cur_col_q != LAST) cur_col_d = cur_col_q + 3'd1;
    end
  end

  logic [5:0] cur_idx;
  logic [5:0] cat_idx;
  logic       sel_ok;

  assign cur_idx = cell_index(cur_row_q, cur_col_q);
  assign cat_idx = cell_index(cat_row_q, cat_col_q);
  assign sel_ok  = !blocked_q[cur_idx] && (cur_idx != cat_idx);

`ifdef CATTRAP_PREBLOCK_EN
  logic [15:0] lfsr_value;
  logic [6:0]  placed_q;
  logic [5:0]  pb_idx;
  logic        pb_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (reset),
    .en   (1'b1),
    .value(lfsr_value)
  );

  assign pb_idx = lfsr_value[5:0];
  assign pb_ok  = !blocked_q[pb_idx] && (pb_idx != cat_idx);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_START;
      blocked_q    <= '0;
      cat_row_q    <= START_ROW;
      cat_col_q    <= START_COL;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      move_count_q <= '0;
      scan_idx_q   <= '0;
      best_q       <= '0;
`ifdef CATTRAP_PREBLOCK_EN
      placed_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_START: begin
          if (bus.BtnC) begin
`ifdef CATTRAP_PREBLOCK_EN
            state_q  <= ST_PREBLOCK;
            placed_q <= '0;
`else
            state_q  <= ST_PLAY;
`endif
          end
        end
`ifdef CATTRAP_PREBLOCK_EN
        ST_PREBLOCK: begin
          if (placed_q >= 7'(PREBLOCK_COUNT)) begin
            state_q <= ST_PLAY;
          end else if (pb_ok) begin
            blocked_q[pb_idx] <= 1'b1;
            placed_q          <= placed_q + 7'd1;
            if (placed_q + 7'd1 >= 7'(PREBLOCK_COUNT)) state_q <= ST_PLAY;
          end
        end
`endif
        ST_PLAY: begin
          // Select outranks movement even when the select itself is refused.
          if (bus.BtnC) begin
            if (sel_ok) begin
              blocked_q[cur_idx] <= 1'b1;
              move_count_q       <= (move_count_q == 7'd127) ? move_count_q : move_count_q + 7'd1;
              state_q            <= ST_CAT_SCAN;
              scan_idx_q         <= '0;
              best_q             <= '0;
            end
          end else begin
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
          end
        end
        ST_CAT_SCAN: begin
          if (scan_idx_q == 3'd4) begin
            if (!best_q.valid) begin
              state_q <= ST_GAMEWIN;
            end else begin
              cat_row_q <= best_q.row;
              cat_col_q <= best_q.col;
              state_q   <= (best_q.score == 3'd0) ? ST_GAMEOVER : ST_PLAY;
            end
          end else begin
            if (nb_take) best_q <= {1'b1, nb_row, nb_col, nb_score};
            scan_idx_q <= scan_idx_q + 3'd1;
          end
        end
        ST_GAMEOVER, ST_GAMEWIN: begin
          if (bus.BtnC) begin
            state_q      <= ST_START;
            blocked_q    <= '0;
            cat_row_q    <= START_ROW;
            cat_col_q    <= START_COL;
            cur_row_q    <= '0;
            cur_col_q    <= '0;
            move_count_q <= '0;
            scan_idx_q   <= '0;
            best_q       <= '0;
          end
        end
        default: state_q <= ST_START;
      endcase
    end
  end

  assign bus.blocked    = blocked_q;
  assign bus.cat_row    = cat_row_q;
  assign bus.cat_col    = cat_col_q;
  assign bus.Row        = 8'b1 << cur_row_q;
  assign bus.Col        = 8'b1 << cur_col_q;
  assign bus.state      = state_q;
  assign bus.move_count = move_count_q;

endmodule
